// File: rtl/axi_mem_slave.sv
// AXI4 memory slave backed by a MEM_WORDS x 64-bit array, INCR bursts of 8-byte beats,
// one transaction outstanding at a time, writes win simultaneous AW/AR requests.
module axi_mem_slave #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int MEM_WORDS      = 512
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                        S_AXI_AWVALID,
    output logic                        S_AXI_AWREADY,
    input  logic [AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [1:0]                  S_AXI_AWBURST,
    input  logic [2:0]                  S_AXI_AWSIZE,
    input  logic [7:0]                  S_AXI_AWLEN,
    input  logic [AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                        S_AXI_WVALID,
    input  logic                        S_AXI_WLAST,
    output logic                        S_AXI_WREADY,
    output logic                        S_AXI_BVALID,
    input  logic                        S_AXI_BREADY,
    output logic [1:0]                  S_AXI_BRESP,
    output logic [AXI_ID_WIDTH-1:0]     S_AXI_BID,
    input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                        S_AXI_ARVALID,
    output logic                        S_AXI_ARREADY,
    input  logic [AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [1:0]                  S_AXI_ARBURST,
    input  logic [2:0]                  S_AXI_ARSIZE,
    input  logic [7:0]                  S_AXI_ARLEN,
    output logic [AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                  S_AXI_RRESP,
    output logic [AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic                        S_AXI_RVALID,
    output logic                        S_AXI_RLAST,
    input  logic                        S_AXI_RREADY
);

    localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
    // Word addresses carry one extra MSB so incrementing past the top never wraps into range.
    localparam int unsigned WA_W   = AXI_ADDR_WIDTH - 2;
    localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
    localparam logic [WA_W-1:0] MEM_LIMIT = WA_W'(MEM_WORDS);

    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

    state_t state_q, state_d;

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic [AXI_ID_WIDTH-1:0] wid_q, rid_q;
    logic [WA_W-1:0]         waddr_q, raddr_q;
    logic [7:0]              wlen_q, wbeat_q, rlen_q, rbeat_q;
    logic                    werr_q, wcfg_err_q, rcfg_err_q;
    logic                    rvalid_q, rlast_q;
    logic [1:0]              rresp_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;

    logic aw_hs, ar_hs, w_hs, r_hs;
    logic aw_cfg_err, ar_cfg_err;
    logic w_last_beat, w_beat_err;
    logic [WA_W-1:0] rd_wa;
    logic rd_err, rd_last, rd_load;
    logic unused_addr_lsbs;

    assign unused_addr_lsbs = ^{S_AXI_AWADDR[2:0], S_AXI_ARADDR[2:0]};

    assign aw_hs = (state_q == IDLE) && S_AXI_AWVALID;
    assign ar_hs = (state_q == IDLE) && S_AXI_ARVALID && !S_AXI_AWVALID;
    assign w_hs  = (state_q == WDATA) && S_AXI_WVALID;
    assign r_hs  = rvalid_q && S_AXI_RREADY;

    assign aw_cfg_err = (S_AXI_AWBURST != 2'b01) || (S_AXI_AWSIZE != 3'd3);
    assign ar_cfg_err = (S_AXI_ARBURST != 2'b01) || (S_AXI_ARSIZE != 3'd3);

    assign w_last_beat = (wbeat_q == wlen_q);
    assign w_beat_err  = wcfg_err_q || (waddr_q >= MEM_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        S_AXI_AWREADY = 1'b0;
        S_AXI_ARREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        S_AXI_BRESP   = 2'b00;
        case (state_q)
            IDLE: begin
                S_AXI_AWREADY = 1'b1;
                S_AXI_ARREADY = !S_AXI_AWVALID;
                if (S_AXI_AWVALID)      state_d = WDATA;
                else if (S_AXI_ARVALID) state_d = RDATA;
            end
            WDATA: begin
                S_AXI_WREADY = 1'b1;
                if (w_hs && w_last_beat) state_d = WRESP;
            end
            WRESP: begin
                S_AXI_BVALID = 1'b1;
                S_AXI_BRESP  = werr_q ? 2'b10 : 2'b00;
                if (S_AXI_BREADY) state_d = IDLE;
            end
            RDATA: begin
                if (r_hs && rlast_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wid_q      <= '0;
            waddr_q    <= '0;
            wlen_q     <= '0;
            wbeat_q    <= '0;
            werr_q     <= 1'b0;
            wcfg_err_q <= 1'b0;
        end else if (aw_hs) begin
            wid_q      <= S_AXI_AWID;
            waddr_q    <= {1'b0, S_AXI_AWADDR[AXI_ADDR_WIDTH-1:3]};
            wlen_q     <= S_AXI_AWLEN;
            wbeat_q    <= '0;
            werr_q     <= aw_cfg_err;
            wcfg_err_q <= aw_cfg_err;
        end else if (w_hs) begin
            waddr_q <= waddr_q + WA_W'(1);
            wbeat_q <= wbeat_q + 8'd1;
            if (w_beat_err || (S_AXI_WLAST != w_last_beat)) werr_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs && !w_beat_err) begin
            for (int unsigned i = 0; i < STRB_W; i++) begin
                if (S_AXI_WSTRB[i]) mem[waddr_q[IDX_W-1:0]][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
            end
        end
    end

    assign S_AXI_BID = wid_q;

    // The next beat is fetched on the AR handshake and on every non-final R handshake,
    // so the registered outputs only change when the master has taken the current beat.
    always_comb begin
        if (state_q == IDLE) begin
            rd_wa   = {1'b0, S_AXI_ARADDR[AXI_ADDR_WIDTH-1:3]};
            rd_err  = ar_cfg_err;
            rd_last = (S_AXI_ARLEN == 8'd0);
        end else begin
            rd_wa   = raddr_q + WA_W'(1);
            rd_err  = rcfg_err_q;
            rd_last = ((rbeat_q + 8'd1) == rlen_q);
        end
        if (rd_wa >= MEM_LIMIT) rd_err = 1'b1;
    end

    assign rd_load = ar_hs || (r_hs && !rlast_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rid_q      <= '0;
            raddr_q    <= '0;
            rlen_q     <= '0;
            rbeat_q    <= '0;
            rcfg_err_q <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rresp_q    <= 2'b00;
            rdata_q    <= '0;
        end else begin
            if (ar_hs) begin
                rid_q      <= S_AXI_ARID;
                rlen_q     <= S_AXI_ARLEN;
                rbeat_q    <= '0;
                rcfg_err_q <= ar_cfg_err;
            end else if (r_hs && !rlast_q) begin
                rbeat_q <= rbeat_q + 8'd1;
            end
            if (rd_load) begin
                raddr_q  <= rd_wa;
                rvalid_q <= 1'b1;
                rlast_q  <= rd_last;
                rresp_q  <= rd_err ? 2'b10 : 2'b00;
                rdata_q  <= rd_err ? '0 : mem[rd_wa[IDX_W-1:0]];
            end else if (r_hs) begin
                rvalid_q <= 1'b0;
                rlast_q  <= 1'b0;
            end
        end
    end

    assign S_AXI_RVALID = rvalid_q;
    assign S_AXI_RLAST  = rlast_q;
    assign S_AXI_RRESP  = rresp_q;
    assign S_AXI_RDATA  = rdata_q;
    assign S_AXI_RID    = rid_q;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed self-checking bench for axi_mem_slave: bursts, strobes, arbitration,
// out-of-range/illegal beats, read back-pressure and reset mid-burst.
module tb_axi_mem_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] awaddr, araddr;
    logic        awvalid, arvalid, awready, arready;
    logic [3:0]  awid, arid, bid, rid;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [2:0]  awsize, arsize;
    logic [7:0]  awlen, arlen;
    logic [63:0] wdata, rdata;
    logic [7:0]  wstrb;
    logic        wvalid, wlast, wready, bvalid, bready, rvalid, rlast, rready;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] d [4];
    logic [63:0] e8 [8];

    always #5 clk = ~clk;

    axi_mem_slave #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4), .MEM_WORDS(512)) dut (
        .clk(clk), .rst_n(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_AWID(awid), .S_AXI_AWBURST(awburst), .S_AXI_AWSIZE(awsize), .S_AXI_AWLEN(awlen),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WLAST(wlast),
        .S_AXI_WREADY(wready), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_BRESP(bresp), .S_AXI_BID(bid),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_ARID(arid), .S_AXI_ARBURST(arburst), .S_AXI_ARSIZE(arsize), .S_AXI_ARLEN(arlen),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RID(rid),
        .S_AXI_RVALID(rvalid), .S_AXI_RLAST(rlast), .S_AXI_RREADY(rready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic aw_send(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id,
                           input logic [1:0] burst, input logic [2:0] size);
        @(negedge clk);
        awaddr = a; awlen = len; awid = id; awburst = burst; awsize = size; awvalid = 1'b1;
        for (int n = 0; n < 20 && !awready; n++) @(negedge clk);
        check("awready", awready, 1'b1);
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [63:0] data, input logic [7:0] strb, input logic last);
        @(negedge clk);
        wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        for (int n = 0; n < 20 && !wready; n++) @(negedge clk);
        check("wready", wready, 1'b1);
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_recv(input string tag, input logic [1:0] exp_resp, input logic [3:0] exp_id);
        @(negedge clk);
        bready = 1'b1;
        for (int n = 0; n < 20 && !bvalid; n++) @(negedge clk);
        check({tag, "_bvalid"}, bvalid, 1'b1);
        check({tag, "_bresp"}, bresp, exp_resp);
        check({tag, "_bid"}, bid, exp_id);
        @(negedge clk);
        bready = 1'b0;
        check({tag, "_bdrop"}, bvalid, 1'b0);
    endtask

    task automatic ar_send(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id,
                           input logic [1:0] burst, input logic [2:0] size);
        @(negedge clk);
        araddr = a; arlen = len; arid = id; arburst = burst; arsize = size; arvalid = 1'b1;
        for (int n = 0; n < 20 && !arready; n++) @(negedge clk);
        check("arready", arready, 1'b1);
        @(negedge clk);
        arvalid = 1'b0;
        check("rvalid_next", rvalid, 1'b1);
    endtask

    task automatic r_recv(input string tag, input logic [63:0] exp_data, input logic [1:0] exp_resp,
                          input logic exp_last, input logic [3:0] exp_id);
        rready = 1'b1;
        for (int n = 0; n < 20 && !rvalid; n++) @(negedge clk);
        check({tag, "_rvalid"}, rvalid, 1'b1);
        check({tag, "_rdata"}, rdata, exp_data);
        check({tag, "_rresp"}, rresp, exp_resp);
        check({tag, "_rlast"}, rlast, exp_last);
        check({tag, "_rid"}, rid, exp_id);
        @(negedge clk);
        rready = 1'b0;
    endtask

    initial begin
        int b;
        logic tog;
        d[0] = 64'h0123_4567_89AB_CDEF;
        d[1] = 64'hFEDC_BA98_7654_3210;
        d[2] = 64'hDEAD_BEEF_CAFE_F00D;
        d[3] = 64'h0F0F_0F0F_F0F0_F0F0;
        for (int k = 0; k < 8; k++) e8[k] = 64'hC0DE_0000_0000_0000 + 64'(k);

        rst_n = 1'b0;
        awaddr = '0; awvalid = 0; awid = '0; awburst = 2'b01; awsize = 3'd3; awlen = '0;
        araddr = '0; arvalid = 0; arid = '0; arburst = 2'b01; arsize = 3'd3; arlen = '0;
        wdata = '0; wstrb = '0; wvalid = 0; wlast = 0; bready = 0; rready = 0;
        repeat (3) @(negedge clk);
        check("rst_awready", awready, 1'b1);
        check("rst_arready", arready, 1'b1);
        check("rst_wready", wready, 1'b0);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_rlast", rlast, 1'b0);
        check("rst_bresp", bresp, 2'b00);
        check("rst_rresp", rresp, 2'b00);
        check("rst_bid", bid, 4'h0);
        check("rst_rid", rid, 4'h0);
        check("rst_rdata", rdata, 64'h0);
        rst_n = 1'b1;

        // 4-beat write then read at 0x40
        aw_send(32'h40, 8'd3, 4'h5, 2'b01, 3'd3);
        for (int k = 0; k < 4; k++) w_send(d[k], 8'hFF, k == 3);
        b_recv("burst4", 2'b00, 4'h5);
        ar_send(32'h40, 8'd3, 4'h9, 2'b01, 3'd3);
        for (int k = 0; k < 4; k++) r_recv("burst4_rd", d[k], 2'b00, k == 3, 4'h9);

        // Partial strobe merge
        aw_send(32'h100, 8'd0, 4'h1, 2'b01, 3'd3);
        w_send(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
        b_recv("fill", 2'b00, 4'h1);
        aw_send(32'h100, 8'd0, 4'h2, 2'b01, 3'd3);
        w_send(64'h1111_2222_3333_4444, 8'h0F, 1'b1);
        b_recv("strb", 2'b00, 4'h2);
        ar_send(32'h100, 8'd0, 4'h3, 2'b01, 3'd3);
        r_recv("strb_rd", 64'hFFFF_FFFF_3333_4444, 2'b00, 1'b1, 4'h3);

        // Simultaneous AW/AR to the same word: write must land first
        @(negedge clk);
        awaddr = 32'h200; awlen = 8'd0; awid = 4'h2; awburst = 2'b01; awsize = 3'd3; awvalid = 1'b1;
        araddr = 32'h200; arlen = 8'd0; arid = 4'h3; arburst = 2'b01; arsize = 3'd3; arvalid = 1'b1;
        #1;
        check("arb_awready", awready, 1'b1);
        check("arb_arready", arready, 1'b0);
        @(negedge clk);
        awvalid = 1'b0;
        check("arb_wready", wready, 1'b1);
        check("arb_ar_wait", arready, 1'b0);
        w_send(64'h5A5A_A5A5_0000_FFFF, 8'hFF, 1'b1);
        check("arb_ar_wresp", arready, 1'b0);
        b_recv("arb", 2'b00, 4'h2);
        check("arb_ar_after_b", arready, 1'b1);
        @(negedge clk);
        arvalid = 1'b0;
        check("arb_rvalid", rvalid, 1'b1);
        r_recv("arb_rd", 64'h5A5A_A5A5_0000_FFFF, 2'b00, 1'b1, 4'h3);

        // Top of array: last two words, then a burst that runs off the end
        aw_send(32'hFF0, 8'd1, 4'h4, 2'b01, 3'd3);
        w_send(64'h5100_0000_0000_0510, 8'hFF, 1'b0);
        w_send(64'h5110_0000_0000_0511, 8'hFF, 1'b1);
        b_recv("top", 2'b00, 4'h4);
        aw_send(32'hFF8, 8'd1, 4'h4, 2'b01, 3'd3);
        w_send(64'hAAAA_0000_0000_0511, 8'hFF, 1'b0);
        w_send(64'hBBBB_0000_0000_0512, 8'hFF, 1'b1);
        b_recv("overrun", 2'b10, 4'h4);
        ar_send(32'hFF0, 8'd3, 4'hA, 2'b01, 3'd3);
        r_recv("oor1", 64'h5100_0000_0000_0510, 2'b00, 1'b0, 4'hA);
        r_recv("oor2", 64'hAAAA_0000_0000_0511, 2'b00, 1'b0, 4'hA);
        r_recv("oor3", 64'h0, 2'b10, 1'b0, 4'hA);
        r_recv("oor4", 64'h0, 2'b10, 1'b1, 4'hA);

        // 8-beat read with RREADY toggling
        aw_send(32'h400, 8'd7, 4'h7, 2'b01, 3'd3);
        for (int k = 0; k < 8; k++) w_send(e8[k], 8'hFF, k == 7);
        b_recv("w8", 2'b00, 4'h7);
        ar_send(32'h400, 8'd7, 4'hB, 2'b01, 3'd3);
        b = 0;
        tog = 1'b0;
        for (int g = 0; g < 64 && b < 8; g++) begin
            rready = tog;
            if (rvalid) begin
                check("r8_data", rdata, e8[b]);
                check("r8_last", rlast, b == 7);
                check("r8_resp", rresp, 2'b00);
                if (tog) b++;
            end
            tog = !tog;
            @(negedge clk);
        end
        rready = 1'b0;
        check("r8_beats", 64'(b), 64'd8);
        check("r8_done", rvalid, 1'b0);

        // Early WLAST
        aw_send(32'h80, 8'd3, 4'h6, 2'b01, 3'd3);
        w_send(64'h1, 8'hFF, 1'b0);
        w_send(64'h2, 8'hFF, 1'b1);
        w_send(64'h3, 8'hFF, 1'b0);
        w_send(64'h4, 8'hFF, 1'b0);
        b_recv("early_wlast", 2'b10, 4'h6);

        // Illegal burst type / size
        aw_send(32'h40, 8'd0, 4'h1, 2'b00, 3'd3);
        w_send(64'h0BAD_0BAD_0BAD_0BAD, 8'hFF, 1'b1);
        b_recv("fixed", 2'b10, 4'h1);
        ar_send(32'h40, 8'd0, 4'hC, 2'b01, 3'd3);
        r_recv("fixed_rd", d[0], 2'b00, 1'b1, 4'hC);
        ar_send(32'h48, 8'd0, 4'hD, 2'b01, 3'd2);
        r_recv("size_rd", 64'h0, 2'b10, 1'b1, 4'hD);

        // Reset mid-burst keeps already-written bytes
        aw_send(32'h500, 8'd3, 4'h8, 2'b01, 3'd3);
        w_send(64'h7777_6666_5555_4444, 8'hFF, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mrst_wready", wready, 1'b0);
        check("mrst_bvalid", bvalid, 1'b0);
        check("mrst_awready", awready, 1'b1);
        check("mrst_bid", bid, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ar_send(32'h500, 8'd0, 4'hE, 2'b01, 3'd3);
        r_recv("mrst_rd", 64'h7777_6666_5555_4444, 2'b00, 1'b1, 4'hE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_mem_slave.md
AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 64, beat width; only 64 is supported.
REQ-003 SHALL have parameter AXI_ID_WIDTH, default 4, transaction ID width.
REQ-004 SHALL have parameter MEM_WORDS, default 512, a power of two giving the 64-bit word count of the backing array.
REQ-005 clk  in  1  single clock, all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 S_AXI_AWADDR / S_AXI_ARADDR  in  AXI_ADDR_WIDTH  write / read burst start address.
REQ-008 S_AXI_AWVALID / S_AXI_ARVALID  in  1  write / read address valid.
REQ-009 S_AXI_AWREADY / S_AXI_ARREADY  out  1  write / read address accept.
REQ-010 S_AXI_AWID / S_AXI_ARID  in  AXI_ID_WIDTH  write / read transaction ID.
REQ-011 S_AXI_AWBURST / S_AXI_ARBURST  in  2  burst type; only INCR (2'b01) is legal.
REQ-012 S_AXI_AWSIZE / S_AXI_ARSIZE  in  3  beat size; only 3'd3 (8 B) is legal.
REQ-013 S_AXI_AWLEN / S_AXI_ARLEN  in  8  beats minus one.
REQ-014 S_AXI_WDATA  in  AXI_DATA_WIDTH  write beat data.
REQ-015 S_AXI_WSTRB  in  AXI_DATA_WIDTH/8  byte enables.
REQ-016 S_AXI_WVALID / S_AXI_WLAST  in  1  write beat valid / final beat.
REQ-017 S_AXI_WREADY  out  1  write beat accept.
REQ-018 S_AXI_BVALID  out  1  write response valid.
REQ-019 S_AXI_BREADY  in  1  write response accept.
REQ-020 S_AXI_BRESP  out  2  write response; 2'b00 OKAY, 2'b10 SLVERR.
REQ-021 S_AXI_BID  out  AXI_ID_WIDTH  echoed AWID.
REQ-022 S_AXI_RDATA  out  AXI_DATA_WIDTH  read beat data.
REQ-023 S_AXI_RRESP  out  2  per-beat read response.
REQ-024 S_AXI_RID  out  AXI_ID_WIDTH  echoed ARID.
REQ-025 S_AXI_RVALID / S_AXI_RLAST  out  1  read beat valid / final beat.
REQ-026 S_AXI_RREADY  in  1  read beat accept.

Function
REQ-027 SHALL implement the FSM IDLE -> WDATA -> WRESP -> IDLE and IDLE -> RDATA -> IDLE, with one transaction outstanding.
REQ-028 In IDLE, AWREADY and ARREADY SHALL both be 1. If AWVALID and ARVALID are both 1 in the same cycle, the write SHALL win, ARREADY SHALL drop that cycle, and the read SHALL wait.
REQ-029 On AW handshake the block SHALL latch ID, address and LEN, clear the beat counter, and enter WDATA; WREADY=1 only in WDATA.
REQ-030 Each W handshake SHALL write bytes with WSTRB[i]=1 to word index addr[3+:log2(MEM_WORDS)] and advance the word address by 1.
REQ-031 WDATA SHALL exit to WRESP on the AWLEN+1-th beat. WLAST on an earlier beat, or absent on that beat, SHALL set the sticky error.
REQ-032 The sticky error SHALL also be set by: BURST != INCR; SIZE != 3; any beat with (addr>>3) >= MEM_WORDS.
REQ-033 Any beat that is erroneous by REQ-032 SHALL be suppressed.
REQ-034 In WRESP: BVALID=1, BID=latched ID, BRESP=SLVERR if sticky error else OKAY. Hold until BREADY, then return to IDLE.
REQ-035 On AR handshake the block SHALL enter RDATA. The first RVALID SHALL rise the next cycle; data SHALL be registered from the array.
REQ-036 Beats SHALL advance only on RVALID&&RREADY, and RDATA/RRESP/RLAST SHALL be held stable while RREADY=0.
REQ-037 Each beat SHALL drive RID=latched ID and RLAST=1 on beat ARLEN+1. RRESP SHALL be SLVERR with RDATA=0 for out-of-range or illegal-burst/size beats, else OKAY.
REQ-038 After the RLAST handshake the block SHALL return to IDLE; back-to-back transactions SHALL need one IDLE cycle.
REQ-039 Addresses SHALL NOT wrap within the array; a beat crossing MEM_WORDS SHALL become an error, not an index wrap.

Reset
REQ-040 When rst_n=0, state=IDLE; AWREADY=ARREADY=1; WREADY=BVALID=RVALID=RLAST=0; BRESP=RRESP=0; BID=RID=0; RDATA=0. Array contents are undefined.
REQ-041 Reset mid-burst SHALL abandon the transaction immediately with no response issued; already-written bytes SHALL remain.

Verification
REQ-042 AW addr 0x40, LEN 3, four beats with full WSTRB, BREADY=1 -> BRESP=OKAY, BID matches. Then AR 0x40, LEN 3 -> same four words, RLAST on beat 4.
REQ-043 Single write WSTRB=0x0F, data 0x1111_2222_3333_4444 over 0xFFFF..FF -> read returns 0xFFFF_FFFF_3333_4444.
REQ-044 AWVALID and ARVALID asserted in the same cycle -> write completes first, then the read starts after the B handshake.
REQ-045 AR addr (MEM_WORDS-2)*8, LEN 3 -> beats 1-2 OKAY; beats 3-4 SLVERR with RDATA 0.
REQ-046 RREADY toggling 1/0 during an 8-beat read -> outputs held while stalled and 8 beats delivered in order. WLAST on beat 2 of LEN 3 -> BRESP=SLVERR.
